// File: rtl/nibble_loaded_addsub_if.sv
// Switch/button side and display side of the nibble-loaded adder/subtractor.
// The board (master) drives buttons, switch data and mode; the datapath (slave) drives results.
interface nibble_loaded_addsub_if #(
    parameter int WIDTH = 7,
    parameter int NIB   = 4
);
    localparam int SLOTS = (WIDTH + NIB - 1) / NIB;
    localparam int PTRW  = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic             pb_a;
    logic             pb_b;
    logic             pb_go;
    logic [NIB-1:0]   y;
    logic             mode;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;
    logic [PTRW-1:0]  a_ptr;
    logic [PTRW-1:0]  b_ptr;

    modport master (
        output pb_a, pb_b, pb_go, y, mode,
        input  sum, cout, ovf, busy, done, a_ptr, b_ptr
    );

    modport slave (
        input  pb_a, pb_b, pb_go, y, mode,
        output sum, cout, ovf, busy, done, a_ptr, b_ptr
    );
endinterface

// File: rtl/nibble_loaded_addsub.sv
// Nibble-loaded operands, nibble-serial add/subtract with carry and signed overflow.
// Latency: go pulse to done = SLOTS+1 cycles; no backpressure, button pulses while busy are dropped.
module nibble_loaded_addsub #(
    parameter int WIDTH = 7,
    parameter int NIB   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_loaded_addsub_if.slave bus
);
    localparam int SLOTS = (WIDTH + NIB - 1) / NIB;
    localparam int PTRW  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int PW    = SLOTS * NIB;
    localparam int TW    = WIDTH - (SLOTS - 1) * NIB;
    localparam logic [PTRW-1:0] LAST = PTRW'(SLOTS - 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state_q, state_d;
    logic [2:0]       s1_q, s2_q, prev_q;
    logic [2:0]       pulse;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [PTRW-1:0]  ap_q, ap_d, bp_q, bp_d, k_q, k_d;
    logic [PW-1:0]    wa_q, wa_d, wb_q, wb_d, part_q, part_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
    logic [NIB:0]     nsum;
    logic             cmsb;

    function automatic logic [WIDTH-1:0] put_nib(input logic [WIDTH-1:0] cur,
                                                 input logic [PTRW-1:0]  p,
                                                 input logic [NIB-1:0]   d);
        return (cur & ~WIDTH'(PW'({NIB{1'b1}}) << (p * NIB))) | WIDTH'(PW'(d) << (p * NIB));
    endfunction

    function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // bit 0 = A, bit 1 = B, bit 2 = go
    assign pulse = s2_q & ~prev_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ap_d    = ap_q;
        bp_d    = bp_q;
        k_d     = k_q;
        wa_d    = wa_q;
        wb_d    = wb_q;
        part_d  = part_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        nsum    = {1'b0, wa_q[NIB-1:0]} + {1'b0, wb_q[NIB-1:0]} + (NIB+1)'(carry_q);
        cmsb    = wa_q[TW-1] ^ wb_q[TW-1] ^ nsum[TW-1];
        case (state_q)
            IDLE: begin
                if (pulse[0]) begin
                    a_d  = put_nib(a_q, ap_q, bus.y);
                    ap_d = ptr_next(ap_q);
                end
                if (pulse[1]) begin
                    b_d  = put_nib(b_q, bp_q, bus.y);
                    bp_d = ptr_next(bp_q);
                end
                // Snapshot uses pre-load operands; a same-cycle load still lands in A/B.
                if (pulse[2]) begin
                    wa_d    = PW'(a_q);
                    wb_d    = PW'(b_q ^ {WIDTH{bus.mode}});
                    carry_d = bus.mode;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                part_d = PW'({nsum[NIB-1:0], part_q} >> NIB);
                wa_d   = wa_q >> NIB;
                wb_d   = wb_q >> NIB;
                if (k_q == LAST) begin
                    // Top slot is only TW bits wide; its zero padding lets the carry land in nsum[TW].
                    sum_d   = part_d[WIDTH-1:0];
                    cout_d  = nsum[TW];
                    ovf_d   = cmsb ^ nsum[TW];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    carry_d = nsum[NIB];
                    k_d     = k_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ap_q    <= '0;
            bp_q    <= '0;
            k_q     <= '0;
            wa_q    <= '0;
            wb_q    <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= {bus.pb_go, bus.pb_b, bus.pb_a};
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            a_q     <= a_d;
            b_q     <= b_d;
            ap_q    <= ap_d;
            bp_q    <= bp_d;
            k_q     <= k_d;
            wa_q    <= wa_d;
            wb_q    <= wb_d;
            part_q  <= part_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
    assign bus.busy  = (state_q == CALC);
    assign bus.done  = done_q;
    assign bus.a_ptr = ap_q;
    assign bus.b_ptr = bp_q;
endmodule

// File: tb/tb_nibble_loaded_addsub.sv
// Bench for nibble_loaded_addsub: directed scenarios plus random button/switch traffic,
// all outputs compared every cycle against an arithmetic reference model.
module tb_nibble_loaded_addsub;
    localparam int W     = 7;
    localparam int N     = 4;
    localparam int SLOTS = (W + N - 1) / N;
    localparam int M     = 1 << W;
    localparam int H     = 1 << (W - 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nibble_loaded_addsub_if #(.WIDTH(W), .NIB(N)) bus ();
    nibble_loaded_addsub #(.WIDTH(W), .NIB(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_a = 0, m_b = 0, m_ap = 0, m_bp = 0;
    int m_sum = 0, m_cout = 0, m_ovf = 0, m_busy = 0, m_done = 0, m_cnt = 0;
    int r_sum, r_cout, r_ovf;
    bit [2:0] h_a = 0, h_b = 0, h_g = 0;   // [0] = last sample, [1] = two edges ago, ...
    bit p_a, p_b, p_g;

    function automatic int ins_nib(input int cur, input int p, input int v);
        int sh;
        sh = p * N;
        return ((cur & ~(((1 << N) - 1) << sh)) | (v << sh)) & (M - 1);
    endfunction

    task automatic calc(input int a, input int b, input bit md, output int s, output int c, output int o);
        int sa, sb, r;
        if (!md) begin
            s = (a + b) % M;
            c = ((a + b) >= M) ? 1 : 0;
        end else begin
            s = (a - b + M) % M;
            c = (a >= b) ? 1 : 0;
        end
        sa = (a >= H) ? a - M : a;
        sb = (b >= H) ? b - M : b;
        r  = md ? sa - sb : sa + sb;
        o  = (r < -H || r > H - 1) ? 1 : 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a = 0; m_b = 0; m_ap = 0; m_bp = 0;
            m_sum = 0; m_cout = 0; m_ovf = 0; m_busy = 0; m_done = 0; m_cnt = 0;
            h_a = 0; h_b = 0; h_g = 0;
        end else begin
            // A press registers two edges after it is first sampled high.
            p_a = h_a[1] & ~h_a[2];
            p_b = h_b[1] & ~h_b[2];
            p_g = h_g[1] & ~h_g[2];
            h_a = {h_a[1:0], bus.pb_a};
            h_b = {h_b[1:0], bus.pb_b};
            h_g = {h_g[1:0], bus.pb_go};
            m_done = 0;
            if (m_busy != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 0; m_done = 1;
                    m_sum = r_sum; m_cout = r_cout; m_ovf = r_ovf;
                end
            end else begin
                if (p_g) begin
                    calc(m_a, m_b, bus.mode, r_sum, r_cout, r_ovf);
                    m_busy = 1;
                    m_cnt  = SLOTS;
                end
                if (p_a) begin m_a = ins_nib(m_a, m_ap, int'(bus.y)); m_ap = (m_ap + 1) % SLOTS; end
                if (p_b) begin m_b = ins_nib(m_b, m_bp, int'(bus.y)); m_bp = (m_bp + 1) % SLOTS; end
            end
        end
    end

    always begin
        @(posedge clk);
        #2;
        chk("sum",   int'(bus.sum),   m_sum);
        chk("cout",  int'(bus.cout),  m_cout);
        chk("ovf",   int'(bus.ovf),   m_ovf);
        chk("busy",  int'(bus.busy),  m_busy);
        chk("done",  int'(bus.done),  m_done);
        chk("a_ptr", int'(bus.a_ptr), m_ap);
        chk("b_ptr", int'(bus.b_ptr), m_bp);
    end

    // ---------------- stimulus helpers ----------------
    // which: 0 = A, 1 = B, 2 = both
    task automatic press(input int which, input int v);
        @(negedge clk);
        bus.y = N'(v);
        if (which != 1) bus.pb_a = 1'b1;
        if (which != 0) bus.pb_b = 1'b1;
        repeat (3) @(negedge clk);
        bus.pb_a = 1'b0;
        bus.pb_b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load2(input int which, input int lo, input int hi);
        press(which, lo);
        press(which, hi);
    endtask

    task automatic go_wait(input bit md, output int lat, output int bcnt);
        @(negedge clk);
        bus.mode  = md;
        bus.pb_go = 1'b1;
        lat  = 0;
        bcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 3) bus.pb_go = 1'b0;
            if (bus.busy) bcnt++;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        bus.pb_go = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_res(input string nm, input int s, input int c, input int o);
        chk({nm, "_sum"},  int'(bus.sum),  s);
        chk({nm, "_cout"}, int'(bus.cout), c);
        chk({nm, "_ovf"},  int'(bus.ovf),  o);
        chk({nm, "_model_sum"}, m_sum, s);
    endtask

    task automatic run_go(input string nm, input bit md, input int s, input int c, input int o);
        int lat, bc;
        go_wait(md, lat, bc);
        chk({nm, "_latency"}, lat, 5);
        expect_res(nm, s, c, o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, bc, dn;
        bus.pb_a = 0; bus.pb_b = 0; bus.pb_go = 0; bus.y = '0; bus.mode = 0;
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sum", int'(bus.sum), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_ptrs", int'(bus.a_ptr) + int'(bus.b_ptr), 0);

        // A = 0x35, B = 0x4A -> 0x7F
        press(0, 5);
        chk("a_ptr_inc", int'(bus.a_ptr), 1);
        press(0, 3);
        load2(1, 'hA, 4);
        chk("a_ptr_wrap", int'(bus.a_ptr), 0);
        chk("b_ptr_wrap", int'(bus.b_ptr), 0);
        go_wait(1'b0, lat, bc);
        chk("go_to_done_latency", lat, 5);   // pulse lands 2 cycles after press, done 3 after that
        chk("busy_cycles", bc, 2);
        expect_res("s1", 'h7F, 0, 0);

        load2(0, 0, 2); load2(1, 0, 2); run_go("ovf_add", 1'b0, 'h40, 0, 1);
        load2(0, 0, 1); load2(1, 0, 2); run_go("sub_borrow", 1'b1, 'h70, 0, 0);
        load2(0, 0, 2); load2(1, 0, 1); run_go("sub_ok", 1'b1, 'h10, 1, 0);
        load2(0, 'hF, 'hF); load2(1, 1, 0); run_go("wrap_add", 1'b0, 'h00, 1, 0);

        // third press wraps to slot 0: A = 0x06
        press(0, 1); press(0, 2); press(0, 6);
        chk("a_ptr_third", int'(bus.a_ptr), 1);
        press(0, 0);
        load2(1, 0, 0);
        run_go("slot0_rewrite", 1'b0, 'h06, 0, 0);

        // presses landing while busy must be ignored
        @(negedge clk);
        bus.mode = 0; bus.pb_go = 1; dn = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 1) begin bus.pb_go = 0; bus.pb_a = 1; bus.y = 'hF; end
            if (i == 2) bus.pb_go = 1;
            if (i == 5) begin bus.pb_go = 0; bus.pb_a = 0; end
            if (bus.done) dn++;
        end
        chk("busy_single_done", dn, 1);
        chk("busy_a_ptr", int'(bus.a_ptr), 0);
        run_go("busy_a_unchanged", 1'b0, 'h06, 0, 0);

        // simultaneous A/B loads
        press(2, 5);
        chk("both_a_ptr", int'(bus.a_ptr), 1);
        chk("both_b_ptr", int'(bus.b_ptr), 1);
        press(2, 0);
        run_go("both_add", 1'b0, 'h0A, 0, 0);

        // reset mid-calculation, pb_a held through reset release
        @(negedge clk);
        bus.mode = 0; bus.pb_go = 1;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", int'(bus.busy), 1);
        rst = 1; bus.pb_go = 0; bus.pb_a = 1; bus.y = 9; dn = 0;
        repeat (2) begin @(negedge clk); dn += int'(bus.done); end
        rst = 0;
        repeat (8) begin @(negedge clk); dn += int'(bus.done); end
        chk("rst_no_done", dn, 0);
        chk("rst_busy_after", int'(bus.busy), 0);
        chk("rst_sum_after", int'(bus.sum), 0);
        chk("held_a_one_load", int'(bus.a_ptr), 1);
        chk("rst_b_ptr", int'(bus.b_ptr), 0);
        bus.pb_a = 0;
        repeat (3) @(negedge clk);
        press(0, 0);
        load2(1, 0, 0);
        run_go("held_slot0", 1'b0, 'h09, 0, 0);

        // random traffic, including bounce, overlap and occasional reset
        repeat (600) begin
            @(negedge clk);
            bus.pb_a  = ($urandom_range(0, 3) == 0);
            bus.pb_b  = ($urandom_range(0, 3) == 0);
            bus.pb_go = ($urandom_range(0, 4) == 0);
            bus.y     = N'($urandom);
            bus.mode  = $urandom_range(0, 1) == 1;
            rst       = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        rst = 0; bus.pb_a = 0; bus.pb_b = 0; bus.pb_go = 0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
